tdc_hit_buffer: RTL and testbench

- Readout stage directly downstream of the TDC channel.
- Captures each finished measurement (tdc_out on tdc_rdy) together with the current bunch-crossing tag (bc_time) into a small synchronous FIFO.
- Presents hits to the readout controller through a request/valid handshake.
- Keeps occupancy and saturating overflow statistics for slow control.

---
 rtl/tdc_pkg.sv | 13 +
 rtl/tdc_sync_fifo.sv | 93 +++++++++
 rtl/tdc_hit_buffer.sv | 86 ++++++++
 tb/tb_tdc_hit_buffer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared widths and the hit record layout for the TDC readout buffer.
package tdc_pkg;

    localparam int TDC_W_DEF = 12;
    localparam int BC_W_DEF  = 7;
    localparam int OVF_W_DEF = 8;

    typedef struct packed {
        logic [BC_W_DEF-1:0]  bc_tag;
        logic [TDC_W_DEF-1:0] tdc_value;
    } hit_t;

endpackage

// File: rtl/tdc_sync_fifo.sv
// Generic single-clock FIFO with registered read data, one-cycle read valid,
// registered occupancy and full/empty flags derived from wrap-bit pointers.
module tdc_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 19
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       wr_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic [W-1:0]  rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          do_rd_s, do_wr_s;

    // A read on a full FIFO frees the slot the simultaneous write lands in.
    always_comb begin
        do_rd_s    = rd_en & ~empty_q;
        do_wr_s    = wr_en & (~full_q | do_rd_s);
        wr_drop    = wr_en & full_q & ~do_rd_s;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = do_rd_s;
        if (do_wr_s) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_rd_s) begin
            rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, 1'b1};
            rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
        end else begin
            rd_ptr_d  = rd_ptr_q;
            rd_data_d = rd_data_q;
        end
        count_d = wr_ptr_d - rd_ptr_d;
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    // Pointer, flag and read-port state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage array; contents are don't-care after reset so it has none.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign count    = count_q;

endmodule

// File: rtl/tdc_hit_buffer.sv
// Readout buffer behind a TDC channel: captures {bc_time, tdc_out} on each
// rising tdc_rdy into a FIFO and keeps a saturating dropped-hit counter.
module tdc_hit_buffer
    import tdc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int TDC_W = TDC_W_DEF,
    parameter int BC_W  = BC_W_DEF,
    parameter int OVF_W = OVF_W_DEF
) (
    input  logic                       clk300,
    input  logic                       reset,
    input  logic                       tdc_rdy,
    input  logic [TDC_W-1:0]           tdc_out,
    input  logic [BC_W-1:0]            bc_time,
    input  logic                       rd_req,
    output logic [BC_W+TDC_W-1:0]      rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [OVF_W-1:0]           ovf_cnt,
    input  logic                       clr_stats
);

    localparam logic [OVF_W-1:0] OVF_MAX = {OVF_W{1'b1}};

    logic                    tdc_rdy_q;
    logic                    wr_stb_s;
    logic                    wr_drop_s;
    logic [BC_W+TDC_W-1:0]   wr_entry_s;
    logic [OVF_W-1:0]        ovf_cnt_q, ovf_cnt_d;

    assign wr_stb_s   = tdc_rdy & ~tdc_rdy_q;
    assign wr_entry_s = {bc_time, tdc_out};

    // Edge-detect register; cleared by reset so a held level counts as a new hit.
    always_ff @(posedge clk300 or negedge reset) begin
        if (!reset) begin
            tdc_rdy_q <= 1'b0;
        end else begin
            tdc_rdy_q <= tdc_rdy;
        end
    end

    tdc_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (BC_W + TDC_W)
    ) u_fifo (
        .clk      (clk300),
        .rst_n    (reset),
        .wr_en    (wr_stb_s),
        .wr_data  (wr_entry_s),
        .rd_en    (rd_req),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .count    (fifo_count),
        .wr_drop  (wr_drop_s)
    );

    // Clear takes priority over a coincident overflow.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (clr_stats) begin
            ovf_cnt_d = {OVF_W{1'b0}};
        end else if (wr_drop_s && (ovf_cnt_q != OVF_MAX)) begin
            ovf_cnt_d = ovf_cnt_q + {{(OVF_W-1){1'b0}}, 1'b1};
        end else begin
            ovf_cnt_d = ovf_cnt_q;
        end
    end

    // Overflow statistics register.
    always_ff @(posedge clk300 or negedge reset) begin
        if (!reset) begin
            ovf_cnt_q <= {OVF_W{1'b0}};
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_tdc_hit_buffer.sv
// Directed self-checking bench for tdc_hit_buffer.
module tb_tdc_hit_buffer;
    import tdc_pkg::*;

    logic        clk300 = 1'b0;
    logic        reset;
    logic        tdc_rdy;
    logic [11:0] tdc_out;
    logic [6:0]  bc_time;
    logic        rd_req;
    logic [18:0] rd_data;
    logic        rd_valid;
    logic        empty;
    logic        full;
    logic [4:0]  fifo_count;
    logic [7:0]  ovf_cnt;
    logic        clr_stats;

    int tests_run = 0;
    int tests_failed = 0;

    tdc_hit_buffer dut (
        .clk300     (clk300),
        .reset      (reset),
        .tdc_rdy    (tdc_rdy),
        .tdc_out    (tdc_out),
        .bc_time    (bc_time),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .empty      (empty),
        .full       (full),
        .fifo_count (fifo_count),
        .ovf_cnt    (ovf_cnt),
        .clr_stats  (clr_stats)
    );

    always #5 clk300 = ~clk300;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk300);
        #1;
    endtask

    function automatic logic [18:0] ent(input logic [6:0] bc, input logic [11:0] v);
        hit_t h;
        h.bc_tag    = bc;
        h.tdc_value = v;
        return h;
    endfunction

    task automatic hit(input logic [6:0] bc, input logic [11:0] v);
        tdc_rdy = 1'b1;
        tdc_out = v;
        bc_time = bc;
        tick();
        tdc_rdy = 1'b0;
        tick();
    endtask

    task automatic read_expect(input string tag, input logic [18:0] exp);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        check({tag, "_data"}, {13'd0, rd_data}, {13'd0, exp});
    endtask

    initial begin
        reset = 1'b0; tdc_rdy = 1'b0; tdc_out = 12'd0; bc_time = 7'd0;
        rd_req = 1'b0; clr_stats = 1'b0;
        tick(); tick();
        check("rst_rd_data", {13'd0, rd_data}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_count", {27'd0, fifo_count}, 32'd0);
        check("rst_ovf", {24'd0, ovf_cnt}, 32'd0);
        reset = 1'b1;
        tick();

        // 1: single hit then single read
        tdc_rdy = 1'b1; tdc_out = 12'h0A5; bc_time = 7'd3;
        tick();
        tdc_rdy = 1'b0; bc_time = 7'd0;
        check("t1_count1", {27'd0, fifo_count}, 32'd1);
        check("t1_notempty", {31'd0, empty}, 32'd0);
        tick();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("t1_valid", {31'd0, rd_valid}, 32'd1);
        check("t1_data", {13'd0, rd_data}, 32'h30A5);
        check("t1_count0", {27'd0, fifo_count}, 32'd0);
        tick();
        check("t1_valid_off", {31'd0, rd_valid}, 32'd0);
        check("t1_data_hold", {13'd0, rd_data}, 32'h30A5);

        // 2: held level gives one entry
        tdc_rdy = 1'b1; tdc_out = 12'h111;
        for (int i = 0; i < 5; i++) tick();
        tdc_rdy = 1'b0;
        tick();
        check("t2_count", {27'd0, fifo_count}, 32'd1);
        check("t2_ovf", {24'd0, ovf_cnt}, 32'd0);
        read_expect("t2_rd", ent(7'd0, 12'h111));
        check("t2_empty", {31'd0, empty}, 32'd1);

        // 3: fill past capacity, then drain back-to-back
        for (int i = 0; i < 18; i++) begin
            hit(7'd0, 12'(i));
            if (i == 14) check("t3_notfull15", {31'd0, full}, 32'd0);
            if (i == 15) check("t3_full16", {31'd0, full}, 32'd1);
        end
        check("t3_ovf", {24'd0, ovf_cnt}, 32'd2);
        check("t3_count", {27'd0, fifo_count}, 32'd16);
        rd_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("t3_bb_valid", {31'd0, rd_valid}, 32'd1);
            check("t3_bb_data", {13'd0, rd_data}, {13'd0, ent(7'd0, 12'(i))});
        end
        rd_req = 1'b0;
        tick();
        check("t3_empty", {31'd0, empty}, 32'd1);
        check("t3_valid_off", {31'd0, rd_valid}, 32'd0);

        // 4: simultaneous write and read while full
        for (int i = 0; i < 16; i++) hit(7'd1, 12'(32 + i));
        check("t4_full", {31'd0, full}, 32'd1);
        tdc_rdy = 1'b1; tdc_out = 12'h055; bc_time = 7'd2; rd_req = 1'b1;
        tick();
        tdc_rdy = 1'b0; rd_req = 1'b0;
        check("t4_valid", {31'd0, rd_valid}, 32'd1);
        check("t4_head", {13'd0, rd_data}, {13'd0, ent(7'd1, 12'd32)});
        check("t4_count", {27'd0, fifo_count}, 32'd16);
        check("t4_ovf", {24'd0, ovf_cnt}, 32'd2);
        tick();
        for (int i = 1; i < 16; i++) read_expect("t4_drain", ent(7'd1, 12'(32 + i)));
        read_expect("t4_new", ent(7'd2, 12'h055));

        // 5: read on empty, overflow with clear
        tick();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("t5_empty_valid", {31'd0, rd_valid}, 32'd0);
        check("t5_empty_data", {13'd0, rd_data}, {13'd0, ent(7'd2, 12'h055)});
        check("t5_empty_count", {27'd0, fifo_count}, 32'd0);
        for (int i = 0; i < 16; i++) hit(7'd5, 12'(64 + i));
        clr_stats = 1'b1;
        hit(7'd5, 12'hFFF);
        clr_stats = 1'b0;
        check("t5_clr_wins", {24'd0, ovf_cnt}, 32'd0);
        hit(7'd5, 12'hFFE);
        check("t5_ovf_inc", {24'd0, ovf_cnt}, 32'd1);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("t5_clr", {24'd0, ovf_cnt}, 32'd0);
        check("t5_count_kept", {27'd0, fifo_count}, 32'd16);

        // 6: reset with 8 entries held and a read in flight
        for (int i = 0; i < 8; i++) read_expect("t6_pre", ent(7'd5, 12'(64 + i)));
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("t6_inflight", {31'd0, rd_valid}, 32'd1);
        check("t6_count7", {27'd0, fifo_count}, 32'd7);
        #1 reset = 1'b0;
        #1;
        check("t6_rst_valid", {31'd0, rd_valid}, 32'd0);
        check("t6_rst_data", {13'd0, rd_data}, 32'd0);
        check("t6_rst_empty", {31'd0, empty}, 32'd1);
        check("t6_rst_count", {27'd0, fifo_count}, 32'd0);
        tick();
        tdc_rdy = 1'b1; tdc_out = 12'h7FF; bc_time = 7'd127;
        reset = 1'b1;
        tick();
        tdc_rdy = 1'b0;
        check("t6_post_count", {27'd0, fifo_count}, 32'd1);
        tick();
        read_expect("t6_bc127", ent(7'd127, 12'h7FF));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
